// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SUB  = 2'd2
    } state_t;

    localparam int unsigned BCD_W         = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
    localparam logic [11:0] SCORE_MAX     = 12'h999;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of an up/down ripple chain; carry-in doubles as borrow-in.
module bcd_digit_step
    import score_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             up,
    input  logic             cin,
    output logic [BCD_W-1:0] digit_nxt,
    output logic             cout
);

    always_comb begin
        digit_nxt = digit;
        cout      = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    digit_nxt = '0;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    digit_nxt = BCD_MAX_DIGIT;
                    cout      = 1'b1;
                end else begin
                    digit_nxt = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/score_bcd_counter.sv
// 3-digit BCD score keeper stepping hit/miss weights one unit per clock.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int unsigned HIT_PTS  = 3,
    parameter int unsigned MISS_PTS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        game_en,
    input  logic        hit,
    input  logic        miss,
    output logic [11:0] bcd,
    output logic        busy,
    output logic        sat,
    output logic        ovf
`ifdef SCORE_HISCORE_EN
    ,
    output logic [11:0] hi_bcd
`endif
);

    localparam logic [3:0] HIT_LD  = 4'(HIT_PTS);
    localparam logic [3:0] MISS_LD = 4'(MISS_PTS);

    state_t      state;
    logic [3:0]  cnt;
    logic        pend_hit;
    logic        pend_miss;

    logic        hit_acc;
    logic        miss_acc;
    logic        eff_hit;
    logic        eff_miss;
    logic [11:0] step_bcd;
    logic [11:0] bcd_nxt;
    logic [3:0]  carry;

    always_comb begin
        hit_acc  = game_en & ~clr & hit;
        miss_acc = game_en & ~clr & miss & (MISS_PTS != 0);
        eff_hit  = pend_hit  | hit_acc;
        eff_miss = pend_miss | miss_acc;
    end

    assign carry[0] = 1'b1;

    bcd_digit_step u_units (
        .digit     (bcd[3:0]),
        .up        (state == ADD),
        .cin       (carry[0]),
        .digit_nxt (step_bcd[3:0]),
        .cout      (carry[1])
    );

    bcd_digit_step u_tens (
        .digit     (bcd[7:4]),
        .up        (state == ADD),
        .cin       (carry[1]),
        .digit_nxt (step_bcd[7:4]),
        .cout      (carry[2])
    );

    bcd_digit_step u_hund (
        .digit     (bcd[11:8]),
        .up        (state == ADD),
        .cin       (carry[2]),
        .digit_nxt (step_bcd[11:8]),
        .cout      (carry[3])
    );

    // A carry/borrow out of the hundreds digit means 999+1 or 000-1: hold.
    assign bcd_nxt = carry[3] ? bcd : step_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_hit  <= 1'b0;
            pend_miss <= 1'b0;
            bcd       <= '0;
            busy      <= 1'b0;
            sat       <= 1'b0;
            ovf       <= 1'b0;
`ifdef SCORE_HISCORE_EN
            hi_bcd    <= '0;
`endif
        end else if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_hit  <= 1'b0;
            pend_miss <= 1'b0;
            bcd       <= '0;
            busy      <= 1'b0;
            sat       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit_acc) begin
                        state     <= ADD;
                        cnt       <= HIT_LD;
                        pend_miss <= miss_acc;
                        busy      <= 1'b1;
                    end else if (miss_acc) begin
                        state <= SUB;
                        cnt   <= MISS_LD;
                        busy  <= 1'b1;
                    end
                end
                ADD, SUB: begin
                    bcd <= bcd_nxt;
                    if (carry[3] && state == ADD) begin
                        sat <= 1'b1;
                    end
                    ovf <= (hit_acc & pend_hit) | (miss_acc & pend_miss);
                    // Events arriving on the final step are folded in before choosing the next burst.
                    if (cnt == 4'd1) begin
                        if (eff_miss) begin
                            state     <= SUB;
                            cnt       <= MISS_LD;
                            pend_miss <= 1'b0;
                            pend_hit  <= eff_hit;
                        end else if (eff_hit) begin
                            state     <= ADD;
                            cnt       <= HIT_LD;
                            pend_hit  <= 1'b0;
                            pend_miss <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            cnt       <= '0;
                            pend_hit  <= 1'b0;
                            pend_miss <= 1'b0;
                            busy      <= 1'b0;
`ifdef SCORE_HISCORE_EN
                            if (bcd_nxt > hi_bcd) begin
                                hi_bcd <= bcd_nxt;
                            end
`endif
                        end
                    end else begin
                        cnt       <= cnt - 4'd1;
                        pend_hit  <= eff_hit;
                        pend_miss <= eff_miss;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
